// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR sequencer: CSR addresses,
// Zicsr funct3 encodings, mstatus bit positions and the sequencer state type.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/csr_rmw.sv
// Combinational Zicsr read-modify-write: new value, write enable (with
// set/clear suppression for a zero source) and illegal-funct3 detection.
module csr_rmw
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [4:0]      i_zimm,
    input  logic            i_rs1_is_x0,
    output logic [XLEN-1:0] o_new_val,
    output logic            o_wr_en,
    output logic            o_illegal
);

    logic [XLEN-1:0] w_src;
    logic            w_src_zero;

    // Select operand and apply the operation selected by funct3
    always_comb begin
        w_src      = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_zimm} : i_rs1_data;
        w_src_zero = i_funct3[2] ? (i_zimm == 5'd0) : i_rs1_is_x0;
        o_new_val  = i_old;
        o_wr_en    = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            F3_CSRRW, F3_CSRRWI: begin
                o_new_val = w_src;
                o_wr_en   = 1'b1;
            end
            F3_CSRRS, F3_CSRRSI: begin
                o_new_val = i_old | w_src;
                o_wr_en   = !w_src_zero;
            end
            F3_CSRRC, F3_CSRRCI: begin
                o_new_val = i_old & ~w_src;
                o_wr_en   = !w_src_zero;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_sequencer.sv
// Machine-mode CSR controller: owns CSR storage, sequences Zicsr requests
// through IDLE/EXEC/RESP, and arbitrates trap entry and mret with redirects.
module csr_sequencer
    import csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_zimm,
    input  logic            req_rs1_is_x0,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    output logic            trap_ack,
    input  logic            mret_valid,
    output logic            mret_ack,
    input  logic            retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    state_e          r_state, w_state_nxt;
    logic            r_live;
    logic [2:0]      r_funct3;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_rs1;
    logic [4:0]      r_zimm;
    logic            r_rs1_x0;
    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mcycle, r_minstret;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_illegal;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_idle, w_take_trap, w_take_mret, w_accept, w_exec, w_wr, w_illegal;
    logic            w_addr_ok, w_rmw_we, w_rmw_illegal;
    logic [XLEN-1:0] w_old, w_new;

    // r_live holds every handshake output low until the first edge after reset
    assign w_idle      = r_live && (r_state == ST_IDLE);
    assign w_take_trap = w_idle && trap_valid;
    assign w_take_mret = w_idle && !trap_valid && mret_valid;
    assign req_ready   = w_idle && !trap_valid && !mret_valid;
    assign w_accept    = req_ready && req_valid;
    assign w_exec      = (r_state == ST_EXEC);
    assign w_illegal   = !w_addr_ok || w_rmw_illegal;
    assign w_wr        = w_exec && !w_illegal && w_rmw_we;

    assign trap_ack       = w_take_trap;
    assign mret_ack       = w_take_mret;
    assign rsp_valid      = (r_state == ST_RESP);
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_illegal    = r_rsp_illegal;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    // CSR read mux and address legality
    always_comb begin
        w_old     = {XLEN{1'b0}};
        w_addr_ok = 1'b1;
        case (r_addr)
            CSR_MSTATUS: begin
                w_old[MSTATUS_MIE]  = r_mie;
                w_old[MSTATUS_MPIE] = r_mpie;
            end
            CSR_MTVEC:    w_old = r_mtvec;
            CSR_MSCRATCH: w_old = r_mscratch;
            CSR_MEPC:     w_old = r_mepc;
            CSR_MCAUSE:   w_old = r_mcause;
            CSR_MCYCLE:   w_old = r_mcycle;
            CSR_MINSTRET: w_old = r_minstret;
            default:      w_addr_ok = 1'b0;
        endcase
    end

    csr_rmw #(.XLEN(XLEN)) u_rmw (
        .i_funct3   (r_funct3),
        .i_old      (w_old),
        .i_rs1_data (r_rs1),
        .i_zimm     (r_zimm),
        .i_rs1_is_x0(r_rs1_x0),
        .o_new_val  (w_new),
        .o_wr_en    (w_rmw_we),
        .o_illegal  (w_rmw_illegal)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, request capture and response latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_live        <= 1'b0;
            r_funct3      <= 3'd0;
            r_addr        <= 12'd0;
            r_rs1         <= {XLEN{1'b0}};
            r_zimm        <= 5'd0;
            r_rs1_x0      <= 1'b0;
            r_rsp_rdata   <= {XLEN{1'b0}};
            r_rsp_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_rs1    <= req_rs1_data;
                r_zimm   <= req_zimm;
                r_rs1_x0 <= req_rs1_is_x0;
            end
            if (w_exec) begin
                r_rsp_rdata   <= w_illegal ? {XLEN{1'b0}} : w_old;
                r_rsp_illegal <= w_illegal;
            end
        end
    end

    // CSR storage; trap, mret and instruction writes are mutually exclusive by state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= {XLEN{1'b0}};
            r_mepc     <= {XLEN{1'b0}};
            r_mcause   <= {XLEN{1'b0}};
        end else if (w_take_trap) begin
            r_mepc   <= trap_pc & ~ONE;
            r_mcause <= trap_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_take_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr) begin
            case (r_addr)
                CSR_MSTATUS: begin
                    r_mie  <= w_new[MSTATUS_MIE];
                    r_mpie <= w_new[MSTATUS_MPIE];
                end
                CSR_MTVEC:    r_mtvec    <= w_new & ~(ONE | (ONE << 1));
                CSR_MSCRATCH: r_mscratch <= w_new;
                CSR_MEPC:     r_mepc     <= w_new & ~ONE;
                CSR_MCAUSE:   r_mcause   <= w_new;
                default: begin
                end
            endcase
        end
    end

    // Free-running counters; an instruction write wins over the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= {XLEN{1'b0}};
            r_minstret <= {XLEN{1'b0}};
        end else begin
            r_mcycle <= (w_wr && r_addr == CSR_MCYCLE) ? w_new : r_mcycle + ONE;
            if (w_wr && r_addr == CSR_MINSTRET) begin
                r_minstret <= w_new;
            end else if (retire) begin
                r_minstret <= r_minstret + ONE;
            end
        end
    end

    // One-cycle fetch redirect following trap entry or mret
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= {XLEN{1'b0}};
        end else if (w_take_trap) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_mtvec;
        end else if (w_take_mret) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_mepc;
        end else begin
            r_redirect_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_sequencer.sv
// Self-checking bench for csr_sequencer: directed scenarios plus randomized
// Zicsr traffic compared against a behavioural CSR model.
module tb_csr_sequencer;

    localparam logic [63:0] MTVEC_RST = 64'h0000_0000_0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [11:0] req_addr = 12'd0;
    logic [63:0] req_rs1_data = 64'd0;
    logic [4:0]  req_zimm = 5'd0;
    logic        req_rs1_is_x0 = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_illegal;
    logic [63:0] rsp_rdata;
    logic        trap_valid = 1'b0, trap_ack;
    logic [63:0] trap_cause = 64'd0, trap_pc = 64'd0;
    logic        mret_valid = 1'b0, mret_ack;
    logic        retire = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    logic        m_mie, m_mpie;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause;

    always #5 clk = ~clk;

    csr_sequencer #(.XLEN(64), .MTVEC_RESET(MTVEC_RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_zimm(req_zimm),
        .req_rs1_is_x0(req_rs1_is_x0),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_illegal(rsp_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_ack(trap_ack), .mret_valid(mret_valid), .mret_ack(mret_ack),
        .retire(retire), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_mtvec = MTVEC_RST;
        m_mscratch = 64'd0; m_mepc = 64'd0; m_mcause = 64'd0;
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: m_read = (m_mie ? 64'h8 : 64'h0) | (m_mpie ? 64'h80 : 64'h0);
            12'h305: m_read = m_mtvec;
            12'h340: m_read = m_mscratch;
            12'h341: m_read = m_mepc;
            12'h342: m_read = m_mcause;
            default: m_read = 64'd0;
        endcase
    endfunction

    // Expected result of a non-counter CSR instruction, updating the model
    task automatic model_op(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] rs1,
                            input logic [4:0] z, input logic x0,
                            output logic [63:0] exp_rd, output logic exp_ill);
        logic [63:0] old, src, nv;
        logic        wr;
        exp_ill = !(a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342}) ||
                  f3 == 3'b000 || f3 == 3'b100;
        exp_rd = 64'd0;
        if (!exp_ill) begin
            old = m_read(a);
            exp_rd = old;
            src = f3[2] ? {59'd0, z} : rs1;
            wr = (f3[1:0] == 2'b01) ? 1'b1 : (f3[2] ? (z != 5'd0) : !x0);
            nv = (f3[1:0] == 2'b01) ? src : (f3[1:0] == 2'b10) ? (old | src) : (old & ~src);
            if (wr) begin
                case (a)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = nv - (nv % 64'd4);
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv - (nv % 64'd2);
                    default: m_mcause = nv;
                endcase
            end
        end
    endtask

    task automatic model_trap(input logic [63:0] cause, input logic [63:0] pc);
        m_mepc = pc - (pc % 64'd2); m_mcause = cause; m_mpie = m_mie; m_mie = 1'b0;
    endtask

    task automatic model_mret();
        m_mie = m_mpie; m_mpie = 1'b1;
    endtask

    // Issue one request and collect its response; lat = negedges from accept to rsp_valid
    task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] rs1,
                         input logic [4:0] z, input logic x0,
                         output logic [63:0] rd, output logic ill, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a;
        req_rs1_data = rs1; req_zimm = z; req_rs1_is_x0 = x0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_timeout: req_ready low for %0d cycles, expected 1 within 50", n);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat >= 50) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid low for %0d cycles, expected 1", lat);
        end
        rd = rsp_rdata;
        ill = rsp_illegal;
        @(posedge clk);
        #1;
    endtask

    task automatic op_check(input string name, input logic [2:0] f3, input logic [11:0] a,
                            input logic [63:0] rs1, input logic [4:0] z, input logic x0);
        logic [63:0] rd, erd;
        logic        ill, eill;
        int          lat;
        model_op(f3, a, rs1, z, x0, erd, eill);
        do_op(f3, a, rs1, z, x0, rd, ill, lat);
        checks++;
        if (rd !== erd || ill !== eill) begin
            errors++;
            $display("FAIL %s: addr=%h f3=%b got rdata=%h ill=%b expected rdata=%h ill=%b",
                     name, a, f3, rd, ill, erd, eill);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || trap_ack !== 1'b0 ||
            mret_ack !== 1'b0 || redirect_valid !== 1'b0 || rsp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b tack=%b mack=%b redir=%b rdata=%h, expected all 0",
                     req_ready, rsp_valid, trap_ack, mret_ack, redirect_valid, rsp_rdata);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
        end
        op_check("reset_mtvec", 3'b010, 12'h305, 64'd0, 5'd0, 1'b1);
        op_check("reset_mscratch_rs_x0", 3'b010, 12'h340, 64'hFFFF, 5'd0, 1'b1);
        op_check("reset_mscratch_unchanged", 3'b010, 12'h340, 64'd0, 5'd0, 1'b1);
    endtask

    task automatic test_rw_basic();
        op_check("csrrw_mscratch", 3'b001, 12'h340, 64'h0000_0000_DEAD_BEEF, 5'd0, 1'b0);
        op_check("csrrc_mscratch", 3'b011, 12'h340, 64'h0000_0000_0000_00FF, 5'd0, 1'b0);
        op_check("read_mscratch", 3'b010, 12'h340, 64'd0, 5'd0, 1'b1);
        checks++;
        if (m_mscratch !== 64'h0000_0000_DEAD_BE00) begin
            errors++;
            $display("FAIL model_mscratch: model=%h expected 00000000deadbe00", m_mscratch);
        end
        op_check("csrrwi_mtvec", 3'b101, 12'h305, 64'd0, 5'h1F, 1'b0);
        op_check("read_mtvec_1c", 3'b010, 12'h305, 64'd0, 5'd0, 1'b1);
        op_check("csrrsi_zero", 3'b110, 12'h305, 64'd0, 5'd0, 1'b0);
        op_check("read_mtvec_after_si0", 3'b010, 12'h305, 64'd0, 5'd0, 1'b1);
    endtask

    task automatic test_illegal();
        op_check("illegal_addr", 3'b001, 12'h7C0, 64'h1234, 5'd0, 1'b0);
        op_check("illegal_f3_100", 3'b100, 12'h340, 64'h5555, 5'd3, 1'b0);
        op_check("illegal_f3_000", 3'b000, 12'h305, 64'h5555, 5'd3, 1'b0);
        op_check("after_illegal_mscratch", 3'b010, 12'h340, 64'd0, 5'd0, 1'b1);
        op_check("after_illegal_mtvec", 3'b010, 12'h305, 64'd0, 5'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd, erd;
        logic        ill, eill;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            model_op(3'b001, 12'h342, 64'(i + 7), 5'd0, 1'b0, erd, eill);
            do_op(3'b001, 12'h342, 64'(i + 7), 5'd0, 1'b0, rd, ill, lat);
            checks++;
            if (lat !== 1 || rd !== erd) begin
                errors++;
                $display("FAIL b2b_latency: lat=%0d rdata=%h expected lat=1 rdata=%h", lat, rd, erd);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] addrs [7];
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0, 12'hF11};
        for (int i = 0; i < 40; i++) begin
            op_check("random_op", 3'($urandom_range(0, 7)), addrs[$urandom_range(0, 6)],
                     {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                     ($urandom_range(0, 2) == 0));
        end
        op_check("random_final_mstatus", 3'b010, 12'h300, 64'd0, 5'd0, 1'b1);
    endtask

    task automatic test_trap_mret();
        op_check("set_mtvec", 3'b001, 12'h305, 64'h0000_0000_0000_2000, 5'd0, 1'b0);
        op_check("set_mie", 3'b101, 12'h300, 64'd0, 5'd8, 1'b0);
        @(negedge clk);
        trap_cause = 64'd11; trap_pc = 64'h0000_0000_8000_0004; trap_valid = 1'b1;
        #1;
        checks++;
        if (trap_ack !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL trap_ack: ack=%b ready=%b expected ack=1 ready=0", trap_ack, req_ready);
        end
        @(posedge clk);
        #1 trap_valid = 1'b0;
        model_trap(64'd11, 64'h0000_0000_8000_0004);
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== m_mtvec) begin
            errors++;
            $display("FAIL trap_redirect: valid=%b pc=%h expected 1 pc=%h", redirect_valid, redirect_pc, m_mtvec);
        end
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_redirect_width: valid=%b expected 0", redirect_valid);
        end
        op_check("trap_mepc", 3'b010, 12'h341, 64'd0, 5'd0, 1'b1);
        op_check("trap_mcause", 3'b010, 12'h342, 64'd0, 5'd0, 1'b1);
        op_check("trap_mstatus", 3'b010, 12'h300, 64'd0, 5'd0, 1'b1);
        @(negedge clk);
        mret_valid = 1'b1;
        #1;
        checks++;
        if (mret_ack !== 1'b1) begin
            errors++;
            $display("FAIL mret_ack: ack=%b expected 1", mret_ack);
        end
        @(posedge clk);
        #1 mret_valid = 1'b0;
        model_mret();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h0000_0000_8000_0004) begin
            errors++;
            $display("FAIL mret_redirect: valid=%b pc=%h expected 1 pc=0000000080000004", redirect_valid, redirect_pc);
        end
        op_check("mret_mstatus", 3'b010, 12'h300, 64'd0, 5'd0, 1'b1);
    endtask

    task automatic test_trap_mret_together();
        @(negedge clk);
        trap_cause = 64'd3; trap_pc = 64'h0000_0000_4000_0011; trap_valid = 1'b1; mret_valid = 1'b1;
        #1;
        checks++;
        if (trap_ack !== 1'b1 || mret_ack !== 1'b0) begin
            errors++;
            $display("FAIL both_priority: tack=%b mack=%b expected 1 0", trap_ack, mret_ack);
        end
        @(posedge clk);
        #1 trap_valid = 1'b0;
        model_trap(64'd3, 64'h0000_0000_4000_0011);
        @(negedge clk);
        checks++;
        if (mret_ack !== 1'b1 || redirect_pc !== m_mtvec || redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL both_mret_after: mack=%b redir=%b pc=%h expected 1 1 %h",
                     mret_ack, redirect_valid, redirect_pc, m_mtvec);
        end
        @(posedge clk);
        #1 mret_valid = 1'b0;
        model_mret();
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== m_mepc) begin
            errors++;
            $display("FAIL both_mret_redirect: valid=%b pc=%h expected 1 %h", redirect_valid, redirect_pc, m_mepc);
        end
        op_check("both_mepc", 3'b010, 12'h341, 64'd0, 5'd0, 1'b1);
    endtask

    task automatic test_stall();
        logic [63:0] erd;
        logic        eill;
        int          n;
        model_op(3'b010, 12'h340, 64'd0, 5'd0, 1'b1, erd, eill);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 12'h340;
        req_rs1_data = 64'd0; req_zimm = 5'd0; req_rs1_is_x0 = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        trap_cause = 64'd7; trap_pc = 64'h0000_0000_0000_1000; trap_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (trap_ack !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== erd) begin
                errors++;
                $display("FAIL stall_hold: cyc=%0d tack=%b rsp_valid=%b rdata=%h expected 0 1 %h",
                         i, trap_ack, rsp_valid, rsp_rdata, erd);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (trap_ack !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_trap_after: tack=%b rsp_valid=%b expected 1 0", trap_ack, rsp_valid);
        end
        @(posedge clk);
        #1 trap_valid = 1'b0;
        model_trap(64'd7, 64'h0000_0000_0000_1000);
        op_check("stall_mcause", 3'b010, 12'h342, 64'd0, 5'd0, 1'b1);
    endtask

    task automatic test_counters();
        logic [63:0] rd;
        logic        ill;
        int          lat;
        do_op(3'b001, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0, 1'b0, rd, ill, lat);
        @(negedge clk);
        retire = 1'b1;
        repeat (3) @(posedge clk);
        #1 retire = 1'b0;
        do_op(3'b010, 12'hB02, 64'd0, 5'd0, 1'b1, rd, ill, lat);
        checks++;
        if (rd !== 64'd1 || ill !== 1'b0) begin
            errors++;
            $display("FAIL minstret_wrap: rdata=%h ill=%b expected 1 0", rd, ill);
        end
        do_op(3'b001, 12'hB00, 64'd0, 5'd0, 1'b0, rd, ill, lat);
        do_op(3'b010, 12'hB00, 64'd0, 5'd0, 1'b1, rd, ill, lat);
        checks++;
        if (rd > 64'd3 || rd < 64'd1) begin
            errors++;
            $display("FAIL mcycle_small: rdata=%0d expected 1..3", rd);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340;
        req_rs1_data = 64'h1234; req_zimm = 5'd0; req_rs1_is_x0 = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: rsp_valid=%b ready=%b expected 0 0", rsp_valid, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_rsp: rsp_valid=%b expected 0", rsp_valid);
            end
        end
        op_check("midreset_mscratch", 3'b010, 12'h340, 64'd0, 5'd0, 1'b1);
        op_check("midreset_mtvec", 3'b010, 12'h305, 64'd0, 5'd0, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_rw_basic();
        test_illegal();
        test_back_to_back();
        test_random();
        test_trap_mret();
        test_trap_mret_together();
        test_stall();
        test_counters();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_sequencer.md
# csr_sequencer

Machine-mode CSR controller for the RV64 core. It owns the CSR storage and sequences Zicsr read-modify-write instructions through a valid/ready request/response handshake. It also arbitrates CSR access between the execute stage, trap entry and `mret`, and issues PC redirects to fetch. It sits beside the ALU in the execute stage; writeback consumes `rsp_rdata`.

## Interface
- `XLEN`, 64: data width.
- `MTVEC_RESET`, 64'h0: reset value of `mtvec`.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  CSR instruction request.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_funct3`  in  3  Zicsr funct3.
- `req_addr`  in  12  CSR address.
- `req_rs1_data`  in  XLEN  rs1 value.
- `req_zimm`  in  5  immediate for *i forms.
- `req_rs1_is_x0`  in  1  rs1 field is x0.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  writeback accepts result.
- `rsp_rdata`  out  XLEN  old CSR value for rd.
- `rsp_illegal`  out  1  illegal CSR instruction.
- `trap_valid`  in  1  trap entry request, held until acked.
- `trap_cause`  in  XLEN  mcause value.
- `trap_pc`  in  XLEN  faulting PC.
- `trap_ack`  out  1  trap taken this cycle.
- `mret_valid`  in  1  mret request, held until acked.
- `mret_ack`  out  1  mret taken this cycle.
- `retire`  in  1  one instruction retired.
- `redirect_valid`  out  1  one-cycle fetch redirect pulse.
- `redirect_pc`  out  XLEN  redirect target.

## Operation
- CSRs:
  - `mstatus` 0x300: only MIE (bit 3) and MPIE (bit 7) are stored; all other bits read 0.
  - `mtvec` 0x305: bits [1:0] forced 0.
  - `mscratch` 0x340.
  - `mepc` 0x341: bit 0 forced 0.
  - `mcause` 0x342.
  - `mcycle` 0xB00.
  - `minstret` 0xB02.
  - Any other address is illegal.
- funct3 and new value:
  - 001 csrrw: src.
  - 010 csrrs: old | src.
  - 011 csrrc: old & ~src.
  - 101/110/111: same operations with src = zero-extended `req_zimm`.
  - For register forms src = `req_rs1_data`.
  - funct3 000/100 are illegal.
- Write suppression: no write for csrrs/csrrc when `req_rs1_is_x0`, and for csrrsi/csrrci when zimm == 0. The old value is still returned.
- Illegal request: `rsp_illegal`=1, `rsp_rdata`=0, no state change.
- FSM states IDLE, EXEC, RESP:
  - IDLE: priority is trap > mret > request. `req_ready` = IDLE && !trap_valid && !mret_valid. An accepted request goes to EXEC.
  - EXEC: read old value, compute new value, write it, latch response. Then go to RESP.
  - RESP: `rsp_valid`=1 with stable data until `rsp_ready`, then back to IDLE.
- Trap entry (in IDLE only): `trap_ack`=1 that cycle. The same edge writes mepc←trap_pc, mcause←trap_cause, MPIE←MIE, MIE←0. The next cycle pulses redirect with `mtvec`.
- mret (in IDLE, no trap pending): `mret_ack`=1 that cycle. The same edge sets MIE←MPIE, MPIE←1. The next cycle pulses redirect with `mepc`.
- Counters:
  - `mcycle` increments every cycle.
  - `minstret` increments when `retire`=1.
  - An instruction write in EXEC overrides the increment that cycle.
  - Both wrap 2^64-1 → 0.

## Timing
- Reset values:
  - Outputs: `req_ready`=0 during reset, 1 in the first IDLE cycle after release; all other outputs 0.
  - CSRs: all 0 except `mtvec`=MTVEC_RESET; state IDLE.
- Request latency: accepted at edge N, EXEC in cycle N+1, `rsp_valid` from cycle N+2. Minimum 3 cycles between back-to-back requests.
- The CSR write is visible to any access starting after the EXEC edge.
- `trap_valid` or `mret_valid` arriving in EXEC/RESP waits until IDLE; an in-flight instruction always completes.
- Trap and mret together in IDLE: the trap wins; mret stays pending.
- Reset asserted mid-operation aborts immediately to reset values; no response is produced.
- `redirect_valid` is exactly one cycle wide.

## Structure
- Shared package `csr_pkg`: CSR address constants, funct3 encodings, mstatus bit indices, FSM state enum.
- One sub-module, `csr_rmw`: combinational new-value and write-enable computation (funct3, old, src, suppression).

## Test plan
- Reset release → `mtvec`=MTVEC_RESET, `req_ready`=1; csrrs x1, mscratch, x0 → rdata 0, no write.
- csrrw mscratch ← 0xDEAD_BEEF, then csrrc with rs1=0xFF → second rdata 0xDEAD_BEEF; mscratch then reads 0xDEAD_BE00.
- csrrwi mtvec zimm=0x1F → mtvec reads 0x1C; csrrsi zimm=0 → no write, old value returned.
- Access 0x7C0 and funct3=100 → `rsp_illegal`=1, rdata 0, all CSRs unchanged.
- MIE=1, trap cause=11, pc=0x8000_0004 → mepc=0x8000_0004, mcause=11, MIE=0, MPIE=1, redirect to mtvec; then mret → MIE=1, redirect to 0x8000_0004.
- Trap raised while RESP is stalled (`rsp_ready`=0 for 5 cycles) → `trap_ack` only after the response handshake; csrrw mcycle←0 → next read of mcycle is small (≤3).
